seg7_display_monitor: RTL and testbench

- Receiving end of the multiplexed seven-segment display interface: snoops the active-low segment bus and active-low digit anodes driven by the display driver and reconstructs the shown hex digits.
- Rejects multiplex transients with a stability filter, flags illegal patterns, and signals per-digit updates and complete frames.
- Sits beside the display driver for self-check and in benches as a scoreboard front-end.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/seg7_pattern_decode.sv | 37 +++
 rtl/seg7_display_monitor.sv | 102 ++++++++++
 tb/tb_seg7_display_monitor.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph patterns (bit6=a .. bit0=g),
// segment bit positions and the decode result type used by the display monitor.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] ZERO_OUT  = 7'b0000001;
  localparam logic [6:0] ONE_OUT   = 7'b1001111;
  localparam logic [6:0] TWO_OUT   = 7'b0010010;
  localparam logic [6:0] THREE_OUT = 7'b0000110;
  localparam logic [6:0] FOUR_OUT  = 7'b1001100;
  localparam logic [6:0] FIVE_OUT  = 7'b0100100;
  localparam logic [6:0] SIX_OUT   = 7'b0100000;
  localparam logic [6:0] SEVEN_OUT = 7'b0001111;
  localparam logic [6:0] EIGHT_OUT = 7'b0000000;
  localparam logic [6:0] NINE_OUT  = 7'b0000100;
  localparam logic [6:0] A_OUT     = 7'b0001000;
  localparam logic [6:0] B_OUT     = 7'b1100000;
  localparam logic [6:0] C_OUT     = 7'b0110001;
  localparam logic [6:0] D_OUT     = 7'b1000010;
  localparam logic [6:0] E_OUT     = 7'b0110000;
  localparam logic [6:0] F_OUT     = 7'b0111000;
  localparam logic [6:0] LEER_OUT  = 7'b1111111;

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Pure table lookup from an active-low segment pattern to {valid, blank, nibble}.
// Undecodable patterns come back with both valid and blank low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output seg7_dec_t  dec
);

  always_comb begin
    dec = '{valid: 1'b1, blank: 1'b0, nibble: 4'h0};
    case (seg)
      ZERO_OUT:  dec.nibble = 4'h0;
      ONE_OUT:   dec.nibble = 4'h1;
      TWO_OUT:   dec.nibble = 4'h2;
      THREE_OUT: dec.nibble = 4'h3;
      FOUR_OUT:  dec.nibble = 4'h4;
      FIVE_OUT:  dec.nibble = 4'h5;
      SIX_OUT:   dec.nibble = 4'h6;
      SEVEN_OUT: dec.nibble = 4'h7;
      EIGHT_OUT: dec.nibble = 4'h8;
      NINE_OUT:  dec.nibble = 4'h9;
      A_OUT:     dec.nibble = 4'hA;
      B_OUT:     dec.nibble = 4'hB;
      C_OUT:     dec.nibble = 4'hC;
      D_OUT:     dec.nibble = 4'hD;
      E_OUT:     dec.nibble = 4'hE;
      F_OUT:     dec.nibble = 4'hF;
      LEER_OUT: begin
        dec.valid = 1'b0;
        dec.blank = 1'b1;
      end
      default:   dec.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_display_monitor.sv
// Snoops a multiplexed active-low seven-segment bus, filters multiplex transients
// and reconstructs the displayed hex digits with per-digit update and frame pulses.
module seg7_display_monitor
  import seg7_pkg::*;
#(
  parameter  int DIGITS        = 2,
  parameter  int STABLE_CYCLES = 4,
  localparam int IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [6:0]            seg_i,
  input  logic [DIGITS-1:0]     an_i,
  output logic [4*DIGITS-1:0]   digit_o,
  output logic [DIGITS-1:0]     blank_o,
  output logic [DIGITS-1:0]     err_o,
  output logic                  upd_o,
  output logic [IDX_W-1:0]      upd_idx_o,
  output logic                  frame_o
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [DIGITS-1:0] mask;
  logic [DIGITS-1:0] mask_set;
  logic [IDX_W-1:0]  idx;
  logic              in_valid;
  logic              same;
  logic              commit;
  logic              frame_hit;
  seg7_dec_t         dec;

  seg7_pattern_decode u_decode (
    .seg (seg_q),
    .dec (dec)
  );

  // Incoming sample is compared against the previous one; seg_q/an_q equal the
  // incoming sample whenever a commit fires, so the decode can use the registered copy.
  always_comb begin
    in_valid = ($countones(~an_i) == 1);
    same     = (seg_i == seg_q) && (an_i == an_q);
    cnt_next = cnt;
    if (!in_valid)
      cnt_next = '0;
    else if (!same)
      cnt_next = CNT_W'(1);
    else if (cnt != CNT_MAX)
      cnt_next = cnt + CNT_W'(1);
    commit = in_valid && same && (cnt == CNT_LAST);
  end

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (!an_q[i]) idx = IDX_W'(i);
    mask_set  = mask | (DIGITS'(1) << idx);
    frame_hit = &mask_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_q     <= LEER_OUT;
      an_q      <= '1;
      cnt       <= '0;
      digit_o   <= '0;
      blank_o   <= '1;
      err_o     <= '0;
      upd_o     <= 1'b0;
      upd_idx_o <= '0;
      frame_o   <= 1'b0;
      mask      <= '0;
    end else begin
      seg_q   <= seg_i;
      an_q    <= an_i;
      cnt     <= cnt_next;
      upd_o   <= commit;
      frame_o <= commit && frame_hit;
      if (commit) begin
        upd_idx_o <= idx;
        mask      <= frame_hit ? '0 : mask_set;
        if (dec.valid) begin
          digit_o[4*idx +: 4] <= dec.nibble;
          blank_o[idx]        <= 1'b0;
          err_o[idx]          <= 1'b0;
        end else if (dec.blank) begin
          blank_o[idx] <= 1'b1;
          err_o[idx]   <= 1'b0;
        end else begin
          err_o[idx] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_display_monitor.sv
// Scoreboard bench for seg7_display_monitor: a sample-history reference model queues
// expected commits, a negedge monitor pops and compares them whenever upd_o fires.
module tb_seg7_display_monitor;

  localparam int DIGITS = 2;
  localparam int S      = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] seg_i = 7'h7F;
  logic [1:0] an_i = 2'b11;
  logic [7:0] digit_o;
  logic [1:0] blank_o;
  logic [1:0] err_o;
  logic       upd_o;
  logic [0:0] upd_idx_o;
  logic       frame_o;

  always #5 clk = ~clk;

  seg7_display_monitor #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .seg_i     (seg_i),
    .an_i      (an_i),
    .digit_o   (digit_o),
    .blank_o   (blank_o),
    .err_o     (err_o),
    .upd_o     (upd_o),
    .upd_idx_o (upd_idx_o),
    .frame_o   (frame_o)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
  } samp_t;

  typedef struct packed {
    logic [0:0] idx;
    logic [7:0] digits;
    logic [1:0] blank;
    logic [1:0] err;
    logic       frame;
  } exp_t;

  logic [6:0] pat_tbl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  exp_t       expq[$];
  samp_t      hist[$];
  logic [7:0] m_digits = '0;
  logic [1:0] m_blank = '1;
  logic [1:0] m_err = '0;
  logic [1:0] m_mask = '0;
  int         tests = 0;
  int         fails = 0;
  int         frame_cnt = 0;

  // Reference model: a commit happens when the last S samples since reset are one
  // identical single-anode sample and the sample just before that run was different.
  always @(posedge clk) begin
    samp_t cur;
    exp_t  e;
    int    n, d, nib;
    bit    run_ok;
    cur = '{seg: seg_i, an: an_i};
    if (!reset_n) begin
      hist.delete();
      m_digits = '0;
      m_blank  = '1;
      m_err    = '0;
      m_mask   = '0;
    end else begin
      hist.push_back(cur);
      if (hist.size() > S + 1) void'(hist.pop_front());
      n = hist.size();
      if (n >= S && $countones(~cur.an) == 1) begin
        run_ok = 1'b1;
        for (int k = n - S; k < n; k++)
          if (hist[k] != cur) run_ok = 1'b0;
        if (run_ok && (n == S || hist[n-S-1] != cur)) begin
          d = (cur.an == 2'b10) ? 0 : 1;
          nib = -1;
          for (int v = 0; v < 16; v++)
            if (pat_tbl[v] == cur.seg) nib = v;
          if (nib >= 0) begin
            m_digits[4*d +: 4] = 4'(nib);
            m_blank[d] = 1'b0;
            m_err[d]   = 1'b0;
          end else if (cur.seg == 7'h7F) begin
            m_blank[d] = 1'b1;
            m_err[d]   = 1'b0;
          end else begin
            m_err[d] = 1'b1;
          end
          m_mask[d] = 1'b1;
          e.frame   = (m_mask == 2'b11);
          if (e.frame) m_mask = '0;
          e.idx    = 1'(d);
          e.digits = m_digits;
          e.blank  = m_blank;
          e.err    = m_err;
          expq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (upd_o) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL spurious_upd: upd_o=1 idx=%0d digit_o=%h, required no commit", upd_idx_o, digit_o);
      end else begin
        e = expq.pop_front();
        if (upd_idx_o !== e.idx || digit_o !== e.digits || blank_o !== e.blank ||
            err_o !== e.err || frame_o !== e.frame) begin
          fails++;
          $display("FAIL commit: got idx=%0d dig=%h blank=%b err=%b frame=%b, required idx=%0d dig=%h blank=%b err=%b frame=%b",
                   upd_idx_o, digit_o, blank_o, err_o, frame_o, e.idx, e.digits, e.blank, e.err, e.frame);
        end
      end
      if (frame_o) frame_cnt++;
    end else begin
      if (frame_o) begin
        tests++;
        fails++;
        $display("FAIL frame_without_upd: frame_o=1 upd_o=0, required frame_o=0");
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        tests++;
        fails++;
        $display("FAIL missing_upd: upd_o=0, required commit idx=%0d dig=%h", e.idx, e.digits);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [6:0] s, input logic [1:0] a, input int n);
    seg_i = s;
    an_i  = a;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int f0;
    logic [6:0] s;
    logic [1:0] a;
    int r;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_digit", 32'(digit_o), 32'h00);
    check("rst_blank", 32'(blank_o), 32'h3);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_upd_frame", {30'd0, upd_o, frame_o}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    f0 = frame_cnt;
    drive(7'b0010010, 2'b10, 10);
    settle();
    check("first_digit", 32'(digit_o), 32'h02);
    check("first_blank", 32'(blank_o), 32'h2);
    check("first_no_frame", 32'(frame_cnt - f0), 32'd0);

    f0 = frame_cnt;
    drive(7'b0110001, 2'b01, 4);
    settle();
    check("second_digit", 32'(digit_o), 32'hC2);
    check("second_frame", 32'(frame_cnt - f0), 32'd1);

    drive(7'b0000110, 2'b10, 3);
    drive(7'b0000110, 2'b11, 1);
    drive(7'b0000110, 2'b10, 3);
    settle();
    check("glitch_digit", 32'(digit_o), 32'hC2);

    drive(7'b1010101, 2'b10, 4);
    settle();
    check("illegal_err", 32'(err_o), 32'h1);
    check("illegal_digit", 32'(digit_o), 32'hC2);
    drive(7'b1111111, 2'b10, 4);
    settle();
    check("blank_err", 32'(err_o), 32'h0);
    check("blank_blank", 32'(blank_o), 32'h1);

    f0 = frame_cnt;
    for (int v = 0; v < 16; v++)
      drive(pat_tbl[v], (v % 2 == 1) ? 2'b01 : 2'b10, 4);
    settle();
    check("sweep_frames", 32'(frame_cnt - f0), 32'd8);
    check("sweep_digit", 32'(digit_o), 32'hFE);

    drive(7'b0100100, 2'b10, 2);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_digit", 32'(digit_o), 32'h00);
    check("midrst_blank", 32'(blank_o), 32'h3);
    check("midrst_upd", {30'd0, upd_o, frame_o}, 32'h0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_early", 32'(upd_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_commit", 32'(upd_o), 32'h1);
    check("midrst_value", 32'(digit_o), 32'h05);
    #1;

    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      s = pat_tbl[$urandom_range(0, 15)];
      else if (r < 8) s = 7'h7F;
      else            s = 7'($urandom);
      r = $urandom_range(0, 9);
      if (r < 4)      a = 2'b10;
      else if (r < 8) a = 2'b01;
      else if (r == 8) a = 2'b11;
      else            a = 2'b00;
      if ($urandom_range(0, 29) == 0) begin
        reset_n = 1'b0;
        drive(s, a, 1);
        reset_n = 1'b1;
      end else begin
        drive(s, a, $urandom_range(1, 7));
      end
    end
    settle();
    check("queue_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
